ripple_carry_adder: RTL and testbench



---
 rtl/ripple_carry_adder_full_adder.sv | 20 ++
 rtl/ripple_carry_adder.sv | 57 +++++
 tb/tb_ripple_carry_adder.sv | 132 +++++++++++++
 3 files changed

// File: rtl/ripple_carry_adder_full_adder.sv
// full_adder: single-bit full adder cell used to build the ripple chain.
//   a, b  : operand bits
//   cin   : carry in
//   s     : sum bit   = a ^ b ^ cin
//   cout  : carry out = (a & b) | (cin & (a ^ b))
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/ripple_carry_adder.sv
// ripple_carry_adder: WIDTH-bit unsigned adder with carry in/out, built as a
// chain of full_adder cells. Reference adder of the adder library.
//   clk    : clock, only used when REGISTER_OUT=1
//   reset  : asynchronous active-low reset, only used when REGISTER_OUT=1
//   a, b   : WIDTH-bit unsigned operands
//   c_in   : carry into bit 0
//   sum    : low WIDTH bits of a + b + c_in
//   c_out  : carry out of bit WIDTH-1
// REGISTER_OUT=0 gives a zero-latency combinational path; REGISTER_OUT=1
// registers sum/c_out on the rising edge of clk (one cycle latency).
module ripple_carry_adder #(
  parameter int unsigned WIDTH        = 64,
  parameter bit          REGISTER_OUT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_c;

  assign carry[0] = c_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .s    (sum_c[i]),
      .cout (carry[i+1])
    );
  end

  if (REGISTER_OUT) begin : g_reg
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sum   <= '0;
        c_out <= 1'b0;
      end else begin
        sum   <= sum_c;
        c_out <= carry[WIDTH];
      end
    end
  end else begin : g_comb
    assign sum   = sum_c;
    assign c_out = carry[WIDTH];
    // clk/reset are intentionally left unconnected in the combinational build
    logic unused_clk_reset;
    assign unused_clk_reset = clk ^ reset;
  end

endmodule

// File: tb/tb_ripple_carry_adder.sv
module tb_ripple_carry_adder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // combinational 64-bit instance
  logic [63:0] a, b, sum_c;
  logic        c_in, cout_c;
  // registered 64-bit instance
  logic [63:0] ra, rb, sum_r;
  logic        rci, cout_r;
  // combinational 1-bit instance
  logic        a1, b1, c1, s1, co1;

  int compared   = 0;
  int mismatched = 0;

  ripple_carry_adder #(.WIDTH(64), .REGISTER_OUT(1'b0)) u_comb (
    .clk(clk), .reset(reset), .a(a), .b(b), .c_in(c_in), .sum(sum_c), .c_out(cout_c)
  );

  ripple_carry_adder #(.WIDTH(64), .REGISTER_OUT(1'b1)) u_reg (
    .clk(clk), .reset(reset), .a(ra), .b(rb), .c_in(rci), .sum(sum_r), .c_out(cout_r)
  );

  ripple_carry_adder #(.WIDTH(1), .REGISTER_OUT(1'b0)) u_w1 (
    .clk(clk), .reset(reset), .a(a1), .b(b1), .c_in(c1), .sum(s1), .c_out(co1)
  );

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic [63:0] av, input logic [63:0] bv, input logic cv);
    @(posedge clk);
    a    = av;
    b    = bv;
    c_in = cv;
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] av, bv;
    logic        cv;
    logic [64:0] exp;
    logic [2:0]  v;

    reset = 1'b1;
    a = '0; b = '0; c_in = 1'b0;
    ra = '0; rb = '0; rci = 1'b0;
    a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
    #2 reset = 1'b0;
    ra = 64'd5; rb = 64'd7; rci = 1'b1;

    // registered outputs cleared and held while reset is low
    #1 check("reg_reset_async", {cout_r, sum_r}, 65'd0);
    @(posedge clk); @(negedge clk);
    check("reg_reset_held", {cout_r, sum_r}, 65'd0);

    // combinational directed vectors (reset low must not gate these)
    apply(64'h0, 64'h0, 1'b0);
    check("zero", {cout_c, sum_c}, 65'd0);
    apply(64'h1234_5678_9ABC_DEF0, 64'h0, 1'b0);
    check("identity", {cout_c, sum_c}, {1'b0, 64'h1234_5678_9ABC_DEF0});
    apply(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
    check("full_ripple", {cout_c, sum_c}, {1'b1, 64'h0});
    apply(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    check("max_overflow", {cout_c, sum_c}, {1'b1, 64'hFFFF_FFFF_FFFF_FFFF});
    apply(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b0);
    check("alt_cin0", {cout_c, sum_c}, {1'b0, 64'hFFFF_FFFF_FFFF_FFFF});
    apply(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1);
    check("alt_cin1", {cout_c, sum_c}, {1'b1, 64'h0});
    apply(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
    check("msb_carry", {cout_c, sum_c}, {1'b1, 64'h0});

    // random regression against a 65-bit reference sum
    for (int i = 0; i < 100; i++) begin
      av  = {$urandom, $urandom};
      bv  = {$urandom, $urandom};
      cv  = 1'($urandom_range(0, 1));
      exp = {1'b0, av} + {1'b0, bv} + {64'd0, cv};
      apply(av, bv, cv);
      check("random", {cout_c, sum_c}, exp);
    end

    // WIDTH=1: exhaustive single full adder
    for (int i = 0; i < 8; i++) begin
      v  = 3'(i);
      a1 = v[2]; b1 = v[1]; c1 = v[0];
      #1 check("w1_full_adder", {63'd0, co1, s1},
               65'(v[2]) + 65'(v[1]) + 65'(v[0]));
    end

    // registered instance: release, then one-cycle latency
    @(negedge clk);
    reset = 1'b1;
    ra = 64'd5; rb = 64'd7; rci = 1'b1;
    @(posedge clk); #1;
    check("reg_first_load", {cout_r, sum_r}, 65'd13);
    @(negedge clk);
    ra = 64'hFFFF_FFFF_FFFF_FFFF; rb = 64'h0; rci = 1'b1;
    check("reg_latency_hold", {cout_r, sum_r}, 65'd13);
    @(posedge clk); #1;
    check("reg_wrap", {cout_r, sum_r}, {1'b1, 64'h0});

    // mid-stream reset clears at once and discards the in-flight result
    @(negedge clk);
    ra = 64'd100; rb = 64'd23; rci = 1'b0;
    @(posedge clk); #2;
    check("reg_pre_reset", {cout_r, sum_r}, 65'd123);
    ra = 64'd1000; rb = 64'd1; rci = 1'b0;
    reset = 1'b0;
    #1 check("reg_mid_reset", {cout_r, sum_r}, 65'd0);
    @(posedge clk); #1;
    check("reg_reset_edge", {cout_r, sum_r}, 65'd0);
    @(negedge clk);
    reset = 1'b1;
    ra = 64'd40; rb = 64'd2; rci = 1'b0;
    check("reg_released_idle", {cout_r, sum_r}, 65'd0);
    @(posedge clk); #1;
    check("reg_after_release", {cout_r, sum_r}, 65'd42);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
